// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the add/sub arbiter: FSM state encodings,
// requester IDs and the round-robin winner selection.
package addsub_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   localparam logic ID_REQ0 = 1'b0;
   localparam logic ID_REQ1 = 1'b1;

   // Round-robin pick: a lone requester wins, a tie goes to the pointer.
   function automatic logic pick_winner(input logic req0, input logic req1, input logic ptr);
      logic win;
      if (req0 && req1) begin
         win = ptr;
      end else if (req1) begin
         win = ID_REQ1;
      end else begin
         win = ID_REQ0;
      end
      return win;
   endfunction

endpackage

// File: rtl/addsub_arbiter_if.sv
// Requester / result bus between the operand sources, the result consumer
// and the add/sub arbiter.
interface addsub_arbiter_if;
   import addsub_arbiter_pkg::*;

   logic       req0;
   logic [3:0] a0;
   logic [3:0] b0;
   logic       mode0;
   logic       req1;
   logic [3:0] a1;
   logic [3:0] b1;
   logic       mode1;
   logic       gnt0;
   logic       gnt1;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_sum;
   logic       res_cout;
   logic       res_ovf;
   logic       res_id;
   logic       busy;

   // Requesters and result consumer side.
   modport master (
      output req0, a0, b0, mode0, req1, a1, b1, mode1, res_ready,
      input  gnt0, gnt1, res_valid, res_sum, res_cout, res_ovf, res_id, busy
   );

   // Arbiter side.
   modport slave (
      input  req0, a0, b0, mode0, req1, a1, b1, mode1, res_ready,
      output gnt0, gnt1, res_valid, res_sum, res_cout, res_ovf, res_id, busy
   );

endinterface

// File: rtl/addsub_arbiter_fourbitaddsub.sv
// Existing 4-bit adder/subtractor: sum = a + (b xor mode) + mode.
module fourbitaddsub (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       mode,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] full_s;

   assign full_s = {1'b0, a} + {1'b0, b ^ {4{mode}}} + {4'b0000, mode};
   assign sum    = full_s[3:0];
   assign cout   = full_s[4];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one fourbitaddsub between two requesters.
// A grant captures the winner's operands, the shared unit computes for one
// cycle, and the registered result is held until the consumer takes it.
module addsub_arbiter #(
   parameter bit FIRST_PRIO = 1'b0
) (
   input logic              clk,
   input logic              rst,
   addsub_arbiter_if.slave  bus
);
   import addsub_arbiter_pkg::*;

   state_t     state_r;
   logic       ptr_r;
   logic [3:0] op_a_r;
   logic [3:0] op_b_r;
   logic       op_mode_r;
   logic       gnt0_r;
   logic       gnt1_r;
   logic       res_valid_r;
   logic [3:0] res_sum_r;
   logic       res_cout_r;
   logic       res_ovf_r;
   logic       res_id_r;
   logic       busy_r;

   logic       any_req_s;
   logic       win_s;
   logic       do_grant_s;
   logic [3:0] sum_s;
   logic       cout_s;
   logic [3:0] b_eff_s;
   logic       ovf_s;

   assign any_req_s = bus.req0 | bus.req1;
   assign win_s     = pick_winner(bus.req0, bus.req1, ptr_r);

   // Decide whether this edge performs an arbitration (from IDLE, or back-to-back from RESP).
   always_comb begin
      do_grant_s = 1'b0;
      case (state_r)
         IDLE:    do_grant_s = any_req_s;
         RESP:    do_grant_s = any_req_s & bus.res_ready;
         EXEC:    do_grant_s = 1'b0;
         default: do_grant_s = 1'b0;
      endcase
   end

   fourbitaddsub u_addsub (
      .a    (op_a_r),
      .b    (op_b_r),
      .mode (op_mode_r),
      .sum  (sum_s),
      .cout (cout_s)
   );

   // Signed overflow: operands of equal sign producing a result of the other sign.
   assign b_eff_s = op_b_r ^ {4{op_mode_r}};
   assign ovf_s   = (op_a_r[3] == b_eff_s[3]) && (sum_s[3] != op_a_r[3]);

   // Control FSM with registered grant, result and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         ptr_r       <= FIRST_PRIO;
         op_a_r      <= 4'b0000;
         op_b_r      <= 4'b0000;
         op_mode_r   <= 1'b0;
         gnt0_r      <= 1'b0;
         gnt1_r      <= 1'b0;
         res_valid_r <= 1'b0;
         res_sum_r   <= 4'b0000;
         res_cout_r  <= 1'b0;
         res_ovf_r   <= 1'b0;
         res_id_r    <= 1'b0;
         busy_r      <= 1'b0;
      end else if (do_grant_s) begin
         state_r     <= EXEC;
         ptr_r       <= ~win_s;
         op_a_r      <= (win_s == ID_REQ1) ? bus.a1    : bus.a0;
         op_b_r      <= (win_s == ID_REQ1) ? bus.b1    : bus.b0;
         op_mode_r   <= (win_s == ID_REQ1) ? bus.mode1 : bus.mode0;
         gnt0_r      <= (win_s == ID_REQ0);
         gnt1_r      <= (win_s == ID_REQ1);
         res_id_r    <= win_s;
         res_valid_r <= 1'b0;
         busy_r      <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               gnt0_r <= 1'b0;
               gnt1_r <= 1'b0;
               busy_r <= 1'b0;
            end
            EXEC: begin
               state_r     <= RESP;
               gnt0_r      <= 1'b0;
               gnt1_r      <= 1'b0;
               res_sum_r   <= sum_s;
               res_cout_r  <= cout_s;
               res_ovf_r   <= ovf_s;
               res_valid_r <= 1'b1;
               busy_r      <= 1'b1;
            end
            RESP: begin
               if (bus.res_ready) begin
                  state_r     <= IDLE;
                  res_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state_r     <= IDLE;
               gnt0_r      <= 1'b0;
               gnt1_r      <= 1'b0;
               res_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt0      = gnt0_r;
   assign bus.gnt1      = gnt1_r;
   assign bus.res_valid = res_valid_r;
   assign bus.res_sum   = res_sum_r;
   assign bus.res_cout  = res_cout_r;
   assign bus.res_ovf   = res_ovf_r;
   assign bus.res_id    = res_id_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: reset, single requesters, round-robin
// alternation, held result under back-pressure and asynchronous reset.
module tb_addsub_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   addsub_arbiter_if bus ();

   addsub_arbiter #(.FIRST_PRIO(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_gnt0"},  {7'd0, bus.gnt0}, 8'd0);
      chk({tag, "_gnt1"},  {7'd0, bus.gnt1}, 8'd0);
      chk({tag, "_valid"}, {7'd0, bus.res_valid}, 8'd0);
      chk({tag, "_busy"},  {7'd0, bus.busy}, 8'd0);
   endtask

   task automatic chk_res(input string tag, input logic [3:0] s, input logic c,
                          input logic o, input logic id);
      chk({tag, "_valid"}, {7'd0, bus.res_valid}, 8'd1);
      chk({tag, "_sum"},   {4'd0, bus.res_sum}, {4'd0, s});
      chk({tag, "_cout"},  {7'd0, bus.res_cout}, {7'd0, c});
      chk({tag, "_ovf"},   {7'd0, bus.res_ovf}, {7'd0, o});
      chk({tag, "_id"},    {7'd0, bus.res_id}, {7'd0, id});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.req0 = 1'b0; bus.a0 = 4'd0; bus.b0 = 4'd0; bus.mode0 = 1'b0;
      bus.req1 = 1'b0; bus.a1 = 4'd0; bus.b1 = 4'd0; bus.mode1 = 1'b0;
      bus.res_ready = 1'b0;
      tick();
      tick();
      chk_idle("reset");
      chk("reset_sum", {4'd0, bus.res_sum}, 8'd0);
      chk("reset_id",  {7'd0, bus.res_id}, 8'd0);
      rst = 1'b0;
      tick();
      chk_idle("post_reset");

      // req0 alone: 1010 + 0010
      bus.req0 = 1'b1; bus.a0 = 4'b1010; bus.b0 = 4'b0010; bus.mode0 = 1'b0;
      bus.res_ready = 1'b1;
      tick();
      chk("t2_gnt0", {7'd0, bus.gnt0}, 8'd1);
      chk("t2_gnt1", {7'd0, bus.gnt1}, 8'd0);
      chk("t2_busy", {7'd0, bus.busy}, 8'd1);
      chk("t2_valid_early", {7'd0, bus.res_valid}, 8'd0);
      bus.req0 = 1'b0;
      tick();
      chk("t2_gnt0_drop", {7'd0, bus.gnt0}, 8'd0);
      chk_res("t2", 4'b1100, 1'b0, 1'b0, 1'b0);
      tick();
      chk_idle("t2_done");

      // req1 alone: 1010 - 0001, then back-to-back 1000 - 1011
      bus.req1 = 1'b1; bus.a1 = 4'b1010; bus.b1 = 4'b0001; bus.mode1 = 1'b1;
      tick();
      chk("t3_gnt1", {7'd0, bus.gnt1}, 8'd1);
      chk("t3_gnt0", {7'd0, bus.gnt0}, 8'd0);
      bus.a1 = 4'b1000; bus.b1 = 4'b1011;
      tick();
      chk_res("t3a", 4'b1001, 1'b1, 1'b0, 1'b1);
      tick();
      chk("t3_gnt1_b2b", {7'd0, bus.gnt1}, 8'd1);
      chk("t3_valid_b2b", {7'd0, bus.res_valid}, 8'd0);
      bus.req1 = 1'b0;
      tick();
      chk_res("t3b", 4'b1101, 1'b0, 1'b0, 1'b1);
      tick();
      chk_idle("t3_done");

      // Asynchronous reset in the middle of EXEC
      bus.req0 = 1'b1; bus.a0 = 4'b1010; bus.b0 = 4'b0010; bus.mode0 = 1'b0;
      tick();
      chk("t1_gnt0", {7'd0, bus.gnt0}, 8'd1);
      #2;
      rst = 1'b1;
      #1;
      chk_idle("t1_async");
      chk("t1_async_id", {7'd0, bus.res_id}, 8'd0);
      bus.req0 = 1'b0;
      rst = 1'b0;
      tick();
      chk_idle("t1_after1");
      tick();
      chk_idle("t1_after2");

      // Both requesting: pointer back at FIRST_PRIO, grants alternate
      bus.req0 = 1'b1; bus.a0 = 4'b0001; bus.b0 = 4'b0001; bus.mode0 = 1'b0;
      bus.req1 = 1'b1; bus.a1 = 4'b0101; bus.b1 = 4'b0010; bus.mode1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_gnt0", {7'd0, bus.gnt0}, (i % 2 == 0) ? 8'd1 : 8'd0);
         chk("t4_gnt1", {7'd0, bus.gnt1}, (i % 2 == 0) ? 8'd0 : 8'd1);
         if (i == 3) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
         end
         tick();
         if (i % 2 == 0) begin
            chk_res("t4_r0", 4'b0010, 1'b0, 1'b0, 1'b0);
         end else begin
            chk_res("t4_r1", 4'b0011, 1'b1, 1'b0, 1'b1);
         end
      end
      tick();
      chk_idle("t4_done");

      // Back-pressure: 0111 + 0001 held while res_ready low, req1 waits
      bus.res_ready = 1'b0;
      bus.req0 = 1'b1; bus.a0 = 4'b0111; bus.b0 = 4'b0001; bus.mode0 = 1'b0;
      tick();
      chk("t5_gnt0", {7'd0, bus.gnt0}, 8'd1);
      bus.req0 = 1'b0;
      bus.req1 = 1'b1; bus.a1 = 4'b0010; bus.b1 = 4'b0011; bus.mode1 = 1'b0;
      tick();
      chk_res("t5_first", 4'b1000, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_res("t5_hold", 4'b1000, 1'b0, 1'b1, 1'b0);
         chk("t5_no_gnt1", {7'd0, bus.gnt1}, 8'd0);
      end
      bus.res_ready = 1'b1;
      tick();
      chk("t5_gnt1", {7'd0, bus.gnt1}, 8'd1);
      chk("t5_valid_drop", {7'd0, bus.res_valid}, 8'd0);
      bus.req1 = 1'b0;
      tick();
      chk_res("t5_r1", 4'b0101, 1'b0, 1'b0, 1'b1);
      tick();
      chk_idle("t5_done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
